// File: rtl/pc_stack.sv
// Program counter confined to [LO,HI] with a DEPTH-entry return-address stack.
// One-cycle latency on Saida/Nivel/Erro; PCEsc=0 freezes all state, no backpressure.
module pc_stack #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] LO        = 8'b10000000,
   parameter logic [WIDTH-1:0] HI        = 8'b11111111,
   parameter logic [WIDTH-1:0] RESET_VEC = 8'b10000000,
   parameter int               DEPTH     = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           PCEsc,
   input  logic [1:0]                     Modo,
   input  logic [WIDTH-1:0]               Entrada,
   output logic [WIDTH-1:0]               Saida,
   output logic [$clog2(DEPTH+1)-1:0]     Nivel,
   output logic                           Vazia,
   output logic                           Cheia,
   output logic                           Erro
);

   localparam int NW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [NW-1:0]    FULL = NW'(DEPTH);
   localparam logic [WIDTH-1:0] SPAN = HI - LO;

   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_JUMP = 2'b01;
   localparam logic [1:0] OP_CALL = 2'b10;
   localparam logic [1:0] OP_RET  = 2'b11;

   logic [WIDTH-1:0] stk [DEPTH];
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] rel;
   logic             in_win;
   logic [NW-1:0]    top_n;

   // Window test as a single unsigned offset compare: Entrada-LO wraps high when below LO.
   assign rel    = Entrada - LO;
   assign in_win = (rel <= SPAN);
   assign seq_pc = (Saida == HI) ? LO : Saida + WIDTH'(1);
   assign top_n  = Nivel - NW'(1);

   assign Vazia = (Nivel == '0);
   assign Cheia = (Nivel == FULL);

   always_ff @(posedge clock) begin
      if (!reset) begin
         Saida <= RESET_VEC;
         Nivel <= '0;
         Erro  <= 1'b0;
      end else begin
         Erro <= 1'b0;
         if (PCEsc) begin
            case (Modo)
               OP_INC: Saida <= seq_pc;
               OP_JUMP: begin
                  if (in_win) Saida <= Entrada;
                  else        Erro  <= 1'b1;
               end
               OP_CALL: begin
                  if (in_win && !Cheia) begin
                     stk[Nivel[AW-1:0]] <= seq_pc;
                     Saida <= Entrada;
                     Nivel <= Nivel + NW'(1);
                  end else begin
                     Erro <= 1'b1;
                  end
               end
               OP_RET: begin
                  if (!Vazia) begin
                     Saida <= stk[top_n[AW-1:0]];
                     Nivel <= top_n;
                  end else begin
                     Erro <= 1'b1;
                  end
               end
               default: Erro <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: each step queues its expected outputs, then checks them after the edge.
module tb_pc_stack;

   localparam logic [1:0] INC  = 2'b00;
   localparam logic [1:0] JUMP = 2'b01;
   localparam logic [1:0] CALL = 2'b10;
   localparam logic [1:0] RET  = 2'b11;

   typedef struct packed {
      logic [7:0] saida;
      logic [2:0] nivel;
      logic       erro;
      logic       vazia;
      logic       cheia;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       PCEsc = 1'b0;
   logic [1:0] Modo = 2'b00;
   logic [7:0] Entrada = 8'h00;
   logic [7:0] Saida;
   logic [2:0] Nivel;
   logic       Vazia;
   logic       Cheia;
   logic       Erro;

   int checks = 0;
   int errors = 0;
   obs_t sb[$];

   pc_stack dut (
      .clock   (clock),
      .reset   (reset),
      .PCEsc   (PCEsc),
      .Modo    (Modo),
      .Entrada (Entrada),
      .Saida   (Saida),
      .Nivel   (Nivel),
      .Vazia   (Vazia),
      .Cheia   (Cheia),
      .Erro    (Erro)
   );

   always #5 clock = ~clock;

   task automatic step(input string tag, input logic rst, input logic en, input logic [1:0] op,
                       input logic [7:0] ent, input logic [7:0] e_pc, input logic [2:0] e_niv,
                       input logic e_err);
      obs_t exp_o;
      obs_t got;
      @(negedge clock);
      reset   = rst;
      PCEsc   = en;
      Modo    = op;
      Entrada = ent;
      exp_o.saida = e_pc;
      exp_o.nivel = e_niv;
      exp_o.erro  = e_err;
      exp_o.vazia = (e_niv == 3'd0);
      exp_o.cheia = (e_niv == 3'd4);
      sb.push_back(exp_o);
      @(posedge clock);
      #1;
      got = '{saida: Saida, nivel: Nivel, erro: Erro, vazia: Vazia, cheia: Cheia};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         exp_o = sb.pop_front();
         assert (got === exp_o) else begin
            errors++;
            $error("FAIL %s observed pc=%h niv=%0d err=%b vaz=%b chе=%b expected pc=%h niv=%0d err=%b vaz=%b che=%b",
                   tag, got.saida, got.nivel, got.erro, got.vazia, got.cheia,
                   exp_o.saida, exp_o.nivel, exp_o.erro, exp_o.vazia, exp_o.cheia);
         end
      end
   endtask

   initial begin
      // reset state
      step("reset", 1'b0, 1'b1, INC, 8'h00, 8'h80, 3'd0, 1'b0);

      // INC through the whole window, wrapping HI -> LO
      for (int k = 1; k <= 130; k++) begin
         logic [7:0] e;
         e = 8'h80 + 8'(k % 128);
         step("inc", 1'b1, 1'b1, INC, 8'h55, e, 3'd0, 1'b0);
      end

      // JUMP outside window is rejected, back-to-back rejects keep Erro high
      step("jump_lo_rej",  1'b1, 1'b1, JUMP, 8'h7F, 8'h82, 3'd0, 1'b1);
      step("jump_lo_rej2", 1'b1, 1'b1, JUMP, 8'h00, 8'h82, 3'd0, 1'b1);
      step("jump_ok",      1'b1, 1'b1, JUMP, 8'hC0, 8'hC0, 3'd0, 1'b0);
      step("hold_inc",     1'b1, 1'b0, INC,  8'h00, 8'hC0, 3'd0, 1'b0);

      // nested CALL/RET
      step("jump_90", 1'b1, 1'b1, JUMP, 8'h90, 8'h90, 3'd0, 1'b0);
      step("call_a0", 1'b1, 1'b1, CALL, 8'hA0, 8'hA0, 3'd1, 1'b0);
      step("call_b0", 1'b1, 1'b1, CALL, 8'hB0, 8'hB0, 3'd2, 1'b0);
      step("ret_a1",  1'b1, 1'b1, RET,  8'h00, 8'hA1, 3'd1, 1'b0);
      step("ret_91",  1'b1, 1'b1, RET,  8'h00, 8'h91, 3'd0, 1'b0);
      step("ret_empty",   1'b1, 1'b1, RET,  8'h00, 8'h91, 3'd0, 1'b1);
      step("call_outwin", 1'b1, 1'b1, CALL, 8'h7F, 8'h91, 3'd0, 1'b1);

      // fill the stack, overflow, drain
      step("call1", 1'b1, 1'b1, CALL, 8'hC0, 8'hC0, 3'd1, 1'b0);
      step("call2", 1'b1, 1'b1, CALL, 8'hC8, 8'hC8, 3'd2, 1'b0);
      step("call3", 1'b1, 1'b1, CALL, 8'hD0, 8'hD0, 3'd3, 1'b0);
      step("call4", 1'b1, 1'b1, CALL, 8'hE0, 8'hE0, 3'd4, 1'b0);
      step("call_full", 1'b1, 1'b1, CALL, 8'hF0, 8'hE0, 3'd4, 1'b1);
      step("hold_ret",  1'b1, 1'b0, RET,  8'h00, 8'hE0, 3'd4, 1'b0);
      step("ret4", 1'b1, 1'b1, RET, 8'h00, 8'hD1, 3'd3, 1'b0);
      step("ret3", 1'b1, 1'b1, RET, 8'h00, 8'hC9, 3'd2, 1'b0);
      step("ret2", 1'b1, 1'b1, RET, 8'h00, 8'hC1, 3'd1, 1'b0);
      step("ret1", 1'b1, 1'b1, RET, 8'h00, 8'h92, 3'd0, 1'b0);
      step("ret_empty2", 1'b1, 1'b1, RET, 8'h00, 8'h92, 3'd0, 1'b1);

      // pushed return address wraps HI -> LO
      step("jump_ff",   1'b1, 1'b1, JUMP, 8'hFF, 8'hFF, 3'd0, 1'b0);
      step("call_wrap", 1'b1, 1'b1, CALL, 8'h90, 8'h90, 3'd1, 1'b0);
      step("ret_wrap",  1'b1, 1'b1, RET,  8'h00, 8'h80, 3'd0, 1'b0);

      // reset wins over a CALL mid-sequence
      step("c1", 1'b1, 1'b1, CALL, 8'hA0, 8'hA0, 3'd1, 1'b0);
      step("c2", 1'b1, 1'b1, CALL, 8'hB0, 8'hB0, 3'd2, 1'b0);
      step("c3", 1'b1, 1'b1, CALL, 8'hC0, 8'hC0, 3'd3, 1'b0);
      step("rst_call",  1'b0, 1'b1, CALL, 8'hD0, 8'h80, 3'd0, 1'b0);
      step("ret_after_rst", 1'b1, 1'b1, RET, 8'h00, 8'h80, 3'd0, 1'b1);
      step("hold_jump", 1'b1, 1'b0, JUMP, 8'h7F, 8'h80, 3'd0, 1'b0);
      step("hold_call", 1'b1, 1'b0, CALL, 8'hA0, 8'h80, 3'd0, 1'b0);
      step("inc_after", 1'b1, 1'b1, INC,  8'h00, 8'h81, 3'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
